// File: rtl/ili9341_cmd_seq.sv
// rtl/ili9341_cmd_seq.sv - ILI9341 power-on, init list and window/pixel command sequencer
module ili9341_cmd_seq #(
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 120000,
    parameter int CMD_WAIT_CYC = 120000,
    parameter int DLY_W        = 24
) (
    input  logic        clk,
    input  logic        rst,
    output logic        tx_send,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        lcd_dc,
    output logic        lcd_cs_n,
    output logic        lcd_rst_n,
    output logic        init_done,
    input  logic        win_req,
    input  logic [15:0] win_x0,
    input  logic [15:0] win_x1,
    input  logic [15:0] win_y0,
    input  logic [15:0] win_y1,
    output logic        win_ack,
    output logic        win_err,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_PWR_RST, S_PWR_WAIT, S_INIT_SEND, S_INIT_WAIT, S_INIT_DLY, S_IDLE,
        S_WIN_SEND, S_WIN_WAIT, S_PIX_WAIT, S_PIX_HI, S_PIX_HI_WAIT,
        S_PIX_LO, S_PIX_LO_WAIT
    } state_t;

    // Counters load N-1 and exit at zero, giving exactly N cycles in the state.
    localparam logic [DLY_W-1:0] RST_LOW_LD  = DLY_W'(RST_LOW_CYC - 1);
    localparam logic [DLY_W-1:0] RST_WAIT_LD = DLY_W'(RST_WAIT_CYC - 1);
    localparam logic [DLY_W-1:0] CMD_WAIT_LD = DLY_W'(CMD_WAIT_CYC - 1);
    localparam logic [3:0]       INIT_LAST   = 4'd6;
    localparam logic [3:0]       WIN_LAST    = 4'd10;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [15:0]       pix_q, pix_d;
    logic              last_q, last_d;
    logic              init_done_q, init_done_d;
    logic              win_ok;
    logic [7:0]        init_byte, win_byte;
    logic              init_dc, win_dc;

    // State and datapath registers; async active-low reset restarts power-on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_PWR_RST;
            dly_q       <= RST_LOW_LD;
            idx_q       <= 4'd0;
            x0_q        <= 16'd0;
            x1_q        <= 16'd0;
            y0_q        <= 16'd0;
            y1_q        <= 16'd0;
            pix_q       <= 16'd0;
            last_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            idx_q       <= idx_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            pix_q       <= pix_d;
            last_q      <= last_d;
            init_done_q <= init_done_d;
        end
    end

    // Init command list and window address bytes, both indexed by idx_q.
    always_comb begin
        init_dc   = 1'b0;
        init_byte = 8'h00;
        case (idx_q)
            4'd0:    init_byte = 8'h01;
            4'd1:    init_byte = 8'h11;
            4'd2:    init_byte = 8'h3A;
            4'd3:    begin init_byte = 8'h55; init_dc = 1'b1; end
            4'd4:    init_byte = 8'h36;
            4'd5:    begin init_byte = 8'h48; init_dc = 1'b1; end
            4'd6:    init_byte = 8'h29;
            default: init_byte = 8'h00;
        endcase
        win_dc   = 1'b1;
        win_byte = 8'h00;
        case (idx_q)
            4'd0:    begin win_byte = 8'h2A; win_dc = 1'b0; end
            4'd1:    win_byte = x0_q[15:8];
            4'd2:    win_byte = x0_q[7:0];
            4'd3:    win_byte = x1_q[15:8];
            4'd4:    win_byte = x1_q[7:0];
            4'd5:    begin win_byte = 8'h2B; win_dc = 1'b0; end
            4'd6:    win_byte = y0_q[15:8];
            4'd7:    win_byte = y0_q[7:0];
            4'd8:    win_byte = y1_q[15:8];
            4'd9:    win_byte = y1_q[7:0];
            4'd10:   begin win_byte = 8'h2C; win_dc = 1'b0; end
            default: win_byte = 8'h00;
        endcase
    end

    // Outputs decoded from state; byte/dc stay fixed from SEND through WAIT.
    always_comb begin
        win_ok    = (win_x0 <= win_x1) && (win_y0 <= win_y1);
        win_ack   = (state_q == S_IDLE) && win_req && win_ok;
        win_err   = (state_q == S_IDLE) && win_req && !win_ok;
        tx_send   = (state_q == S_INIT_SEND) || (state_q == S_WIN_SEND) ||
                    (state_q == S_PIX_HI) || (state_q == S_PIX_LO);
        lcd_rst_n = (state_q != S_PWR_RST);
        busy      = (state_q != S_IDLE);
        pix_ready = (state_q == S_PIX_WAIT);
        init_done = init_done_q;
        tx_byte   = 8'h00;
        lcd_dc    = 1'b0;
        lcd_cs_n  = 1'b0;
        case (state_q)
            S_INIT_SEND, S_INIT_WAIT:  begin tx_byte = init_byte;    lcd_dc = init_dc; end
            S_WIN_SEND, S_WIN_WAIT:    begin tx_byte = win_byte;     lcd_dc = win_dc;  end
            S_PIX_HI, S_PIX_HI_WAIT:   begin tx_byte = pix_q[15:8];  lcd_dc = 1'b1;    end
            S_PIX_LO, S_PIX_LO_WAIT:   begin tx_byte = pix_q[7:0];   lcd_dc = 1'b1;    end
            default:                   begin tx_byte = 8'h00;        lcd_dc = 1'b0;    end
        endcase
        case (state_q)
            S_PWR_RST, S_PWR_WAIT, S_INIT_DLY: lcd_cs_n = 1'b1;
            S_IDLE:                            lcd_cs_n = !win_ack;
            default:                           lcd_cs_n = 1'b0;
        endcase
    end

    // Next-state sequencing: power-on, init list, window setup, pixel stream.
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        idx_d       = idx_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        pix_d       = pix_q;
        last_d      = last_q;
        init_done_d = init_done_q;
        case (state_q)
            S_PWR_RST: begin
                if (dly_q == '0) begin
                    state_d = S_PWR_WAIT;
                    dly_d   = RST_WAIT_LD;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_PWR_WAIT: begin
                if (dly_q == '0) begin
                    state_d = S_INIT_SEND;
                    idx_d   = 4'd0;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_INIT_SEND: state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (tx_done) begin
                    if (idx_q == INIT_LAST) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        // SWRESET and SLPOUT each need a settle delay afterwards.
                        if (idx_q == 4'd0 || idx_q == 4'd1) begin
                            state_d = S_INIT_DLY;
                            dly_d   = CMD_WAIT_LD;
                        end else begin
                            state_d = S_INIT_SEND;
                        end
                    end
                end
            end
            S_INIT_DLY: begin
                if (dly_q == '0) state_d = S_INIT_SEND;
                else             dly_d   = dly_q - DLY_W'(1);
            end
            S_IDLE: begin
                if (win_ack) begin
                    x0_d    = win_x0;
                    x1_d    = win_x1;
                    y0_d    = win_y0;
                    y1_d    = win_y1;
                    idx_d   = 4'd0;
                    state_d = S_WIN_SEND;
                end
            end
            S_WIN_SEND: state_d = S_WIN_WAIT;
            S_WIN_WAIT: begin
                if (tx_done) begin
                    if (idx_q == WIN_LAST) begin
                        state_d = S_PIX_WAIT;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_WIN_SEND;
                    end
                end
            end
            S_PIX_WAIT: begin
                if (pix_valid) begin
                    pix_d   = pix_data;
                    last_d  = pix_last;
                    state_d = S_PIX_HI;
                end
            end
            S_PIX_HI:      state_d = S_PIX_HI_WAIT;
            S_PIX_HI_WAIT: if (tx_done) state_d = S_PIX_LO;
            S_PIX_LO:      state_d = S_PIX_LO_WAIT;
            S_PIX_LO_WAIT: if (tx_done) state_d = last_q ? S_IDLE : S_PIX_WAIT;
            default:       state_d = S_PWR_RST;
        endcase
    end

endmodule

// File: tb/tb_ili9341_cmd_seq.sv
// tb/tb_ili9341_cmd_seq.sv - self-checking bench for ili9341_cmd_seq
module tb_ili9341_cmd_seq;
    localparam int RLC = 4;
    localparam int RWC = 6;
    localparam int CWC = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_send, tx_done, lcd_dc, lcd_cs_n, lcd_rst_n, init_done;
    logic [7:0]  tx_byte;
    logic        win_req, win_ack, win_err;
    logic [15:0] win_x0, win_x1, win_y0, win_y1;
    logic [15:0] pix_data;
    logic        pix_valid, pix_last, pix_ready, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int init_rise_cyc = 0;
    logic [7:0] log_b[$];
    logic       log_dc[$];
    int         send_cyc[$];
    int         done_cyc[$];

    ili9341_cmd_seq #(
        .RST_LOW_CYC(RLC), .RST_WAIT_CYC(RWC), .CMD_WAIT_CYC(CWC), .DLY_W(24)
    ) dut (
        .clk(clk), .rst(rst), .tx_send(tx_send), .tx_byte(tx_byte), .tx_done(tx_done),
        .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .lcd_rst_n(lcd_rst_n), .init_done(init_done),
        .win_req(win_req), .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .win_ack(win_ack), .win_err(win_err), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_ready(pix_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte engine: answers each tx_send with tx_done after 3..10 cycles.
    initial begin : engine
        int lat;
        bit aborted;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_send === 1'b1) begin
                lat = $urandom_range(3, 10);
                aborted = 0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    if (rst !== 1'b1) aborted = 1;
                end
                #1;
                if (!aborted && rst === 1'b1) begin
                    tx_done = 1'b1;
                    @(posedge clk);
                    #1;
                    tx_done = 1'b0;
                end
            end
        end
    end

    // Bus monitor: logs bytes, checks hold/handshake/chip-select rules.
    initial begin : monitor
        logic       inflight;
        logic [7:0] hb;
        logic       hdc;
        logic       prev_init;
        inflight = 1'b0;
        prev_init = 1'b0;
        hb = 8'h00;
        hdc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst !== 1'b1) begin
                inflight = 1'b0;
                prev_init = 1'b0;
            end else begin
                if (inflight) begin
                    chk("hold_byte", tx_byte, hb);
                    chk("hold_dc", lcd_dc, hdc);
                end
                if (tx_send === 1'b1) begin
                    chk("send_without_done", inflight, 1'b0);
                    chk("cs_at_send", lcd_cs_n, 1'b0);
                    log_b.push_back(tx_byte);
                    log_dc.push_back(lcd_dc);
                    send_cyc.push_back(cyc);
                    inflight = 1'b1;
                    hb = tx_byte;
                    hdc = lcd_dc;
                end
                if (tx_done === 1'b1) begin
                    chk("cs_at_done", lcd_cs_n, 1'b0);
                    done_cyc.push_back(cyc);
                    inflight = 1'b0;
                end
                if (win_ack === 1'b1) ack_cnt++;
                if (win_err === 1'b1) err_cnt++;
                if (init_done === 1'b1 && !prev_init) init_rise_cyc = cyc;
                prev_init = init_done;
            end
        end
    end

    task automatic clear_log();
        log_b.delete();
        log_dc.delete();
        send_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic check_reset();
        chk("rst_tx_send", tx_send, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_lcd_dc", lcd_dc, 1'b0);
        chk("rst_cs_n", lcd_cs_n, 1'b1);
        chk("rst_lcd_rst_n", lcd_rst_n, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_win_ack", win_ack, 1'b0);
        chk("rst_win_err", win_err, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
    endtask

    task automatic compare_log(input string tag, input logic [7:0] eb[$], input logic ed[$]);
        chk({tag, "_count"}, log_b.size(), eb.size());
        if (log_b.size() == eb.size()) begin
            for (int i = 0; i < eb.size(); i++) begin
                chk({tag, "_byte"}, {i[7:0], log_b[i]}, {i[7:0], eb[i]});
                chk({tag, "_dc"}, {i[7:0], 7'd0, log_dc[i]}, {i[7:0], 7'd0, ed[i]});
            end
        end
    endtask

    // Releases reset and checks the full power-on / init sequence.
    task automatic power_on();
        int n;
        logic [7:0] eb[$];
        logic       ed[$];
        eb = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        clear_log();
        rst = 1'b1;
        @(negedge clk);
        n = 0;
        while (lcd_rst_n === 1'b0 && n < 100) begin n++; @(negedge clk); end
        chk("rst_low_cycles", n, RLC);
        n = 0;
        while (tx_send !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("rst_wait_cycles", n, RWC);
        chk("first_byte", tx_byte, 8'h01);
        chk("first_dc", lcd_dc, 1'b0);
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
        chk("init_done_seen", init_done, 1'b1);
        @(negedge clk);
        compare_log("init", eb, ed);
        if (send_cyc.size() == 7 && done_cyc.size() == 7) begin
            chk("swreset_delay", send_cyc[1] - done_cyc[0] - 1, CWC);
            chk("slpout_delay", send_cyc[2] - done_cyc[1] - 1, CWC);
            chk("init_done_after_dispon", init_rise_cyc - done_cyc[6], 1);
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_cs_n", lcd_cs_n, 1'b1);
    endtask

    // One window request plus its pixels, checked against a byte-level model.
    task automatic run_window(input logic [15:0] x0, input logic [15:0] x1,
                              input logic [15:0] y0, input logic [15:0] y1,
                              input logic [15:0] pix[$]);
        logic [7:0] eb[$];
        logic       ed[$];
        logic       legal;
        logic       hs;
        int a0, e0, n;
        clear_log();
        a0 = ack_cnt;
        e0 = err_cnt;
        legal = (x0 <= x1) && (y0 <= y1);
        @(posedge clk); #1;
        win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
        win_req = 1'b1;
        @(negedge clk);
        chk("win_ack_pulse", win_ack, legal);
        chk("win_err_pulse", win_err, !legal);
        @(posedge clk); #1;
        win_req = 1'b0;
        win_x0 = 16'($urandom); win_x1 = 16'($urandom);
        win_y0 = 16'($urandom); win_y1 = 16'($urandom);
        if (!legal) begin
            repeat (12) @(negedge clk);
            chk("err_no_send", log_b.size(), 0);
            chk("err_count", err_cnt - e0, 1);
            chk("err_no_ack", ack_cnt - a0, 0);
            chk("err_cs_n", lcd_cs_n, 1'b1);
            chk("err_busy", busy, 1'b0);
            return;
        end
        eb = '{8'h2A, 8'((x0 >> 8) & 16'hFF), 8'(x0 & 16'hFF), 8'((x1 >> 8) & 16'hFF), 8'(x1 & 16'hFF),
               8'h2B, 8'((y0 >> 8) & 16'hFF), 8'(y0 & 16'hFF), 8'((y1 >> 8) & 16'hFF), 8'(y1 & 16'hFF),
               8'h2C};
        ed = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < pix.size(); k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            pix_data  = pix[k];
            pix_last  = (k == pix.size() - 1);
            pix_valid = 1'b1;
            hs = 1'b0;
            n = 0;
            while (!hs && n < 500) begin
                @(negedge clk);
                hs = (pix_ready === 1'b1);
                @(posedge clk); #1;
                n++;
            end
            chk("pix_handshake", hs, 1'b1);
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            eb.push_back(8'(pix[k] >> 8));
            eb.push_back(8'(pix[k] & 16'hFF));
            ed.push_back(1'b1);
            ed.push_back(1'b1);
        end
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin n++; @(negedge clk); end
        @(negedge clk);
        compare_log("win", eb, ed);
        chk("win_ack_once", ack_cnt - a0, 1);
        chk("win_no_err", err_cnt - e0, 0);
        chk("win_end_cs_n", lcd_cs_n, 1'b1);
        chk("win_end_busy", busy, 1'b0);
    endtask

    initial begin : main
        logic [15:0] pq[$];
        int n;
        rst = 1'b0;
        win_req = 1'b0;
        win_x0 = 16'd0; win_x1 = 16'd0; win_y0 = 16'd0; win_y1 = 16'd0;
        pix_data = 16'd0; pix_valid = 1'b0; pix_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        power_on();

        pq = '{16'hF800, 16'h07E0, 16'h001F};
        run_window(16'h0010, 16'h001F, 16'h0000, 16'h013F, pq);

        pq = '{};
        run_window(16'h0020, 16'h0010, 16'h0000, 16'h0010, pq);

        for (int r = 0; r < 6; r++) begin
            logic [15:0] a, b, c, d;
            a = 16'($urandom_range(0, 200));
            b = 16'($urandom_range(0, 239));
            c = 16'($urandom_range(0, 280));
            d = 16'($urandom_range(0, 319));
            pq = '{};
            for (int k = 0; k < $urandom_range(1, 4); k++) pq.push_back(16'($urandom));
            run_window(a, b, c, d, pq);
        end

        // Abort mid-pixel: reset right after the high byte of the first pixel goes out.
        clear_log();
        @(posedge clk); #1;
        win_x0 = 16'h0010; win_x1 = 16'h001F; win_y0 = 16'h0000; win_y1 = 16'h013F;
        win_req = 1'b1;
        @(posedge clk); #1;
        win_req = 1'b0;
        pix_data = 16'hF800; pix_last = 1'b0; pix_valid = 1'b1;
        n = 0;
        while (log_b.size() < 12 && n < 2000) begin n++; @(posedge clk); end
        #1;
        chk("abort_reached_hi_byte", log_b.size(), 12);
        if (log_b.size() == 12) chk("abort_hi_byte", log_b[11], 8'hF8);
        rst = 1'b0;
        pix_valid = 1'b0;
        #1;
        check_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        power_on();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
